// File: rtl/seg_pkg.sv
// Shared constants for the memory-mapped seven-segment display controller:
// register map, CTRL bit positions, scan states and the segment lookup table.
package seg_pkg;

    localparam logic [3:0] OFS_DATA = 4'h0;
    localparam logic [3:0] OFS_CTRL = 4'h4;
    localparam logic [3:0] OFS_RAW  = 4'h8;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_RAW       = 1;
    localparam int CTRL_BLANK_LSB = 4;
    localparam int CTRL_DP_LSB    = 8;

    typedef enum logic [1:0] {
        SCAN0 = 2'd0,
        SCAN1 = 2'd1,
        SCAN2 = 2'd2,
        SCAN3 = 2'd3
    } scan_state_e;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first so index n selects digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/seg_display_ctrl.sv
// Memory-mapped four-digit common-anode display controller: register bank on
// the MEM-stage bus, refresh counter and digit-scan FSM with registered outputs.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
    parameter int          SCAN_DIV  = 100000,
    parameter int          CNT_W     = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        sel,
    output logic [3:0]  an,
    output logic [7:0]  bcd
);

    logic [15:0]      r_data;
    logic             r_en;
    logic             r_raw;
    logic [3:0]       r_blank;
    logic [3:0]       r_dp;
    logic [11:0]      r_rawreg;
    logic [CNT_W-1:0] r_cnt;
    scan_state_e      r_state;
    scan_state_e      w_state_nxt;

    logic [29:0] w_ofs;
    logic [3:0]  w_byte_ofs;
    logic        w_wr_data;
    logic        w_wr_ctrl;
    logic        w_wr_raw;
    logic        w_scan_clr;
    logic        w_tc;
    logic [1:0]  w_k;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;
    logic [3:0]  w_an_nxt;
    logic [7:0]  w_bcd_nxt;
    logic        w_unused;

    // Word-granular decode; byte offsets within a word are ignored.
    assign w_ofs      = addr[31:2] - BASE_ADDR[31:2];
    assign sel        = (addr[31:2] >= BASE_ADDR[31:2]) && (w_ofs < 30'd3);
    assign w_byte_ofs = {w_ofs[1:0], 2'b00};
    assign w_wr_data  = we && sel && (w_byte_ofs == OFS_DATA);
    assign w_wr_ctrl  = we && sel && (w_byte_ofs == OFS_CTRL);
    assign w_wr_raw   = we && sel && (w_byte_ofs == OFS_RAW);
    assign w_unused   = ^{addr[1:0], wdata[31:16]};

    always_comb begin
        rdata = '0;
        if (re && sel) begin
            case (w_byte_ofs)
                OFS_DATA: rdata = {16'b0, r_data};
                OFS_CTRL: rdata = {20'b0, r_dp, r_blank, 2'b00, r_raw, r_en};
                OFS_RAW:  rdata = {20'b0, r_rawreg};
                default:  rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data   <= '0;
            r_en     <= 1'b0;
            r_raw    <= 1'b0;
            r_blank  <= '0;
            r_dp     <= '0;
            r_rawreg <= 12'hFFF;
        end else begin
            if (w_wr_data) r_data <= wdata[15:0];
            if (w_wr_ctrl) begin
                r_en    <= wdata[CTRL_EN];
                r_raw   <= wdata[CTRL_RAW];
                r_blank <= wdata[CTRL_BLANK_LSB +: 4];
                r_dp    <= wdata[CTRL_DP_LSB +: 4];
            end
            if (w_wr_raw) r_rawreg <= wdata[11:0];
        end
    end

    // Disabling (either already off or being written off) parks the scan at SCAN0/0.
    assign w_scan_clr = !r_en || (w_wr_ctrl && !wdata[CTRL_EN]);
    assign w_tc       = (r_cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_state <= SCAN0;
        end else begin
            r_cnt   <= (w_scan_clr || w_tc) ? '0 : r_cnt + 1'b1;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_scan_clr) begin
            w_state_nxt = SCAN0;
        end else if (w_tc) begin
            case (r_state)
                SCAN0:   w_state_nxt = SCAN1;
                SCAN1:   w_state_nxt = SCAN2;
                SCAN2:   w_state_nxt = SCAN3;
                default: w_state_nxt = SCAN0;
            endcase
        end
    end

    assign w_k   = r_state;
    assign w_nib = r_data[{w_k, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .i_nibble (w_nib),
        .o_seg    (w_seg)
    );

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_bcd_nxt = 8'hFF;
        if (r_en) begin
            if (r_raw) begin
                {w_an_nxt, w_bcd_nxt} = r_rawreg;
            end else begin
                w_an_nxt  = ~(4'b0001 << w_k) | r_blank;
                w_bcd_nxt = {~r_dp[w_k], w_seg};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1111;
            bcd <= 8'hFF;
        end else begin
            an  <= w_an_nxt;
            bcd <= w_bcd_nxt;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a short refresh divider.
module tb_seg_display_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        sel;
    logic [3:0]  an;
    logic [7:0]  bcd;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] AN_T  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] BCD_T [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    seg_display_ctrl #(
        .BASE_ADDR (BASE),
        .SCAN_DIV  (4),
        .CNT_W     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .rdata (rdata),
        .sel   (sel),
        .an    (an),
        .bcd   (bcd)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        addr  = 32'h0;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        we    = 1'b0;
        re    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_an", {28'b0, an}, 32'hF);
        chk("rst_bcd", {24'b0, bcd}, 32'hFF);
        chk("rst_rdata", rdata, 32'h0);
        reset = 1'b1;
        addr  = BASE + 32'h4;
        re    = 1'b1;
        #1;
        chk("rst_ctrl_rd", rdata, 32'h0);
        chk("rst_ctrl_sel", {31'b0, sel}, 32'h1);
        re = 1'b0;

        // Basic scan of 0x1234
        wr(BASE, 32'h1234);
        wr(BASE + 32'h4, 32'h001);
        @(negedge clk);
        chk("scan_lat_an", {28'b0, an}, 32'hF);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("scan_an_%0d", i), {28'b0, an}, {28'b0, AN_T[i/4]});
            chk($sformatf("scan_bcd_%0d", i), {24'b0, bcd}, {24'b0, BCD_T[i/4]});
        end
        @(negedge clk);
        chk("scan_wrap_an", {28'b0, an}, 32'hE);

        // Register reads and decode boundaries
        addr = BASE + 32'h4; re = 1'b1; #1;
        chk("rd_ctrl", rdata, 32'h1);
        chk("rd_ctrl_sel", {31'b0, sel}, 32'h1);
        addr = BASE + 32'h6; #1;
        chk("rd_ctrl_byteofs", rdata, 32'h1);
        addr = BASE - 32'h4; #1;
        chk("below_sel", {31'b0, sel}, 32'h0);
        chk("below_rdata", rdata, 32'h0);
        addr = BASE + 32'hC; #1;
        chk("above_sel", {31'b0, sel}, 32'h0);
        addr = BASE + 32'h4; re = 1'b0; #1;
        chk("no_re_rdata", rdata, 32'h0);
        addr = 32'h0;

        // All digits blanked
        wr(BASE + 32'h4, 32'h0F1);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("blank_an_%0d", i), {28'b0, an}, 32'hF);
        end

        // Decimal point on digit 0
        wr(BASE + 32'h4, 32'h100);
        wr(BASE + 32'h4, 32'h101);
        @(negedge clk);
        chk("dp_lat_an", {28'b0, an}, 32'hF);
        chk("dp_lat_bcd", {24'b0, bcd}, 32'hFF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("dp_an_%0d", i), {28'b0, an}, 32'hE);
            chk($sformatf("dp_bcd_%0d", i), {24'b0, bcd}, 32'h19);
        end
        @(negedge clk);
        chk("dp_d1_an", {28'b0, an}, 32'hD);
        chk("dp_d1_bcd", {24'b0, bcd}, 32'hB0);

        // Raw drive, counter keeps running underneath
        wr(BASE + 32'h4, 32'h000);
        wr(BASE + 32'h8, 32'h5A0);
        wr(BASE + 32'h4, 32'h003);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("raw_an_%0d", i), {28'b0, an}, 32'h5);
            chk($sformatf("raw_bcd_%0d", i), {24'b0, bcd}, 32'hA0);
        end
        wr(BASE + 32'h4, 32'h001);
        @(negedge clk);
        chk("unraw_lat_an", {28'b0, an}, 32'h5);
        @(negedge clk);
        chk("unraw_an_a", {28'b0, an}, 32'hB);
        chk("unraw_bcd_a", {24'b0, bcd}, 32'hA4);
        @(negedge clk);
        chk("unraw_an_b", {28'b0, an}, 32'hB);
        @(negedge clk);
        chk("unraw_an_c", {28'b0, an}, 32'h7);
        chk("unraw_bcd_c", {24'b0, bcd}, 32'hF9);

        // Asynchronous reset in the middle of the digit-2 dwell
        n = 0;
        while (an !== 4'hB && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("dig2_wait", {28'b0, an}, 32'hB);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_an", {28'b0, an}, 32'hF);
        chk("mid_rst_bcd", {24'b0, bcd}, 32'hFF);
        @(negedge clk);
        reset = 1'b1;
        addr  = BASE;
        re    = 1'b1;
        #1;
        chk("post_rst_data", rdata, 32'h0);
        re = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_an", {28'b0, an}, 32'hF);

        // Simultaneous write and read, then unused-bit masking
        wr(BASE, 32'hABCD);
        @(negedge clk);
        addr  = BASE;
        wdata = 32'hFFFF_FFFF;
        we    = 1'b1;
        re    = 1'b1;
        #1;
        chk("rw_old", rdata, 32'hABCD);
        @(posedge clk);
        #1;
        we = 1'b0;
        chk("rw_new_masked", rdata, 32'h0000_FFFF);
        addr = BASE + 32'h8;
        #1;
        chk("raw_after_rst", rdata, 32'h0000_0FFF);
        re = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
